repair_seq_ctrl: RTL and testbench

REPAIR_SEQ_CTRL -- requirements
Module: repair_seq_ctrl

---
 rtl/repair_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_repair_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/repair_seq_ctrl.sv
// repair_seq_ctrl
//   Searches for a spare-row repair solution. The set of occupied PCAM entries
//   is captured at start. Candidate selection vectors that use exactly
//   k = min(popcount(occupied), SPARE) occupied entries are then issued in
//   ascending numeric order to an external coverage checker. The search stops
//   on the first passing candidate, when the candidates run out, or when the
//   checker does not answer in time.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle search request, honoured only in IDLE
//   pcam_valid   in   [PCAM] occupied PCAM entries (bit PCAM-1 = entry 0)
//   chk_done     in   checker finished evaluating the issued candidate
//   chk_pass     in   candidate covers all faults (qualified by chk_done)
//   dsss         out  [PCAM] candidate selection vector to the address mux
//   dsss_valid   out  one-cycle strobe for a new candidate on dsss
//   busy         out  search in progress (LOAD through DONE)
//   done         out  one-cycle completion pulse
//   repairable   out  search result, held until the next accepted start
//   timeout      out  search ended because the checker did not answer
//   tried_cnt    out  [8] candidates issued, saturating at 255
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; results of the last search held
// LOAD  | register k, reset candidate counter
// SCAN  | test one candidate per cycle against occupancy and weight k
// ISSUE | present candidate on dsss with a one-cycle strobe
// WAIT  | wait for checker verdict or timer expiry
// DONE  | one-cycle completion pulse, then back to IDLE

module repair_seq_ctrl #(
    parameter int PCAM    = 8,
    parameter int SPARE   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PCAM-1:0] pcam_valid,
    input  logic            chk_done,
    input  logic            chk_pass,
    output logic [PCAM-1:0] dsss,
    output logic            dsss_valid,
    output logic            busy,
    output logic            done,
    output logic            repairable,
    output logic            timeout,
    output logic [7:0]      tried_cnt
);

    localparam int KW = $clog2(PCAM + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]      state;
    logic [PCAM-1:0] valid_q;
    logic [PCAM-1:0] cand;
    logic [KW-1:0]   k;
    logic [TW-1:0]   timer;
    logic            cand_match;
    logic            cand_last;

    function automatic logic [KW-1:0] popcount(input logic [PCAM-1:0] v);
        logic [KW-1:0] c;
        c = '0;
        for (int i = 0; i < PCAM; i++) begin
            c = c + KW'(v[i]);
        end
        return c;
    endfunction

    // A candidate may only select occupied entries and must use exactly k.
    assign cand_match = ((cand & ~valid_q) == '0) && (popcount(cand) == k);
    assign cand_last  = (cand == '1);

    assign dsss_valid = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            valid_q    <= '0;
            cand       <= '0;
            k          <= '0;
            timer      <= '0;
            dsss       <= '0;
            repairable <= 1'b0;
            timeout    <= 1'b0;
            tried_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        valid_q    <= pcam_valid;
                        repairable <= 1'b0;
                        timeout    <= 1'b0;
                        tried_cnt  <= '0;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (int'(popcount(valid_q)) > SPARE) begin
                        k <= KW'(SPARE);
                    end else begin
                        k <= popcount(valid_q);
                    end
                    cand  <= '0;
                    state <= S_SCAN;
                end
                S_SCAN: begin
                    if (cand_match) begin
                        dsss  <= cand;
                        state <= S_ISSUE;
                    end else if (cand_last) begin
                        repairable <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        cand <= cand + PCAM'(1);
                    end
                end
                S_ISSUE: begin
                    if (tried_cnt != 8'hFF) begin
                        tried_cnt <= tried_cnt + 8'd1;
                    end
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A checker answer on the expiry cycle wins over timeout.
                    if (chk_done) begin
                        if (chk_pass) begin
                            repairable <= 1'b1;
                            state      <= S_DONE;
                        end else if (cand_last) begin
                            repairable <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            cand  <= cand + PCAM'(1);
                            state <= S_SCAN;
                        end
                    end else if (timer == TMAX) begin
                        repairable <= 1'b0;
                        timeout    <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_repair_seq_ctrl.sv
// tb_repair_seq_ctrl
//   Directed bench for repair_seq_ctrl with default parameters
//   (PCAM=8, SPARE=4, TIMEOUT=64). Expected values are hand-derived.

module tb_repair_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pcam_valid;
    logic       chk_done;
    logic       chk_pass;
    logic [7:0] dsss;
    logic       dsss_valid;
    logic       busy;
    logic       done;
    logic       repairable;
    logic       timeout;
    logic [7:0] tried_cnt;

    int n_cmp;
    int n_err;

    repair_seq_ctrl #(.PCAM(8), .SPARE(4), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pcam_valid (pcam_valid),
        .chk_done   (chk_done),
        .chk_pass   (chk_pass),
        .dsss       (dsss),
        .dsss_valid (dsss_valid),
        .busy       (busy),
        .done       (done),
        .repairable (repairable),
        .timeout    (timeout),
        .tried_cnt  (tried_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] pv);
        pcam_valid = pv;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Steps until dsss_valid is seen or the budget runs out; n = steps taken.
    task automatic wait_strobe(input int max, output int n);
        n = 0;
        while (!dsss_valid && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            step();
            n++;
        end
    endtask

    initial begin
        int         n;
        int         idx;
        int         guard;
        logic [7:0] first_d;
        logic [7:0] last_d;
        logic [7:0] exp_q[$];
        logic       order_ok;

        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        pcam_valid = 8'h00;
        chk_done   = 1'b0;
        chk_pass   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_dsss", dsss, 8'h00);
        chk("rst_strobe", dsss_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rep", repairable, 1'b0);
        chk("rst_tmo", timeout, 1'b0);
        chk("rst_tried", tried_cnt, 8'd0);
        rst = 1'b0;
        step();

        // Empty PCAM: k=0, candidate 0x00 issued in cycle 3 after start
        do_start(8'h00);
        chk("t1_busy", busy, 1'b1);
        wait_strobe(20, n);
        chk("t1_lat", n + 1, 3);
        chk("t1_dsss", dsss, 8'h00);
        step();
        chk("t1_tried", tried_cnt, 8'd1);
        chk("t1_strobe_1cyc", dsss_valid, 1'b0);
        chk_done = 1'b1;
        chk_pass = 1'b1;
        step();
        chk_done = 1'b0;
        chk_pass = 1'b0;
        chk("t1_done", done, 1'b1);
        chk("t1_rep", repairable, 1'b1);
        step();
        chk("t1_done_1cyc", done, 1'b0);
        chk("t1_idle", busy, 1'b0);
        chk("t1_rep_hold", repairable, 1'b1);

        // Two entries: 0x03 issued 6 cycles after start; pass
        do_start(8'h03);
        chk("t2_rep_clr", repairable, 1'b0);
        wait_strobe(20, n);
        chk("t2_lat", n + 1, 6);
        chk("t2_dsss", dsss, 8'h03);
        step();
        chk_done = 1'b1;
        chk_pass = 1'b1;
        step();
        chk_done = 1'b0;
        chk_pass = 1'b0;
        chk("t2_done", done, 1'b1);
        chk("t2_rep", repairable, 1'b1);
        chk("t2_dsss_hold", dsss, 8'h03);
        step();

        // Full PCAM, checker always fails after 2 cycles: all C(8,4)=70 weight-4 vectors
        for (int v = 0; v < 256; v++) begin
            if ($countones(v[7:0]) == 4) exp_q.push_back(v[7:0]);
        end
        do_start(8'hFF);
        idx      = 0;
        guard    = 0;
        first_d  = 8'h00;
        last_d   = 8'h00;
        order_ok = 1'b1;
        while (!done && guard < 5000) begin
            if (dsss_valid) begin
                if (idx == 0) first_d = dsss;
                last_d = dsss;
                if (idx >= exp_q.size() || dsss !== exp_q[idx]) order_ok = 1'b0;
                idx++;
                step();
                step();
                chk_done = 1'b1;
                chk_pass = 1'b0;
                step();
                chk_done = 1'b0;
            end else begin
                step();
            end
            guard++;
        end
        chk("t3_done", done, 1'b1);
        chk("t3_strobes", idx, 70);
        chk("t3_order", order_ok, 1'b1);
        chk("t3_first", first_d, 8'h0F);
        chk("t3_last", last_d, 8'hF0);
        chk("t3_rep", repairable, 1'b0);
        chk("t3_tmo", timeout, 1'b0);
        chk("t3_tried", tried_cnt, 8'd70);
        step();

        // Five entries, checker never answers: timeout 65 cycles after ISSUE
        do_start(8'h1F);
        wait_strobe(40, n);
        chk("t4_strobe", dsss_valid, 1'b1);
        chk("t4_dsss", dsss, 8'h0F);
        wait_done(200, n);
        chk("t4_tmo_lat", n, 65);
        chk("t4_tmo", timeout, 1'b1);
        chk("t4_rep", repairable, 1'b0);
        chk("t4_tried", tried_cnt, 8'd1);
        step();
        chk("t4_tmo_hold", timeout, 1'b1);

        // Reset during WAIT, stray chk_done in IDLE, then 0x81
        do_start(8'h1F);
        wait_strobe(40, n);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_dsss", dsss, 8'h00);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_tried", tried_cnt, 8'd0);
        chk("t5_rst_strobe", dsss_valid, 1'b0);
        chk("t5_rst_done", done, 1'b0);
        chk("t5_rst_rep", repairable, 1'b0);
        chk("t5_rst_tmo", timeout, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        chk_done = 1'b1;
        chk_pass = 1'b1;
        step();
        chk_done = 1'b0;
        chk_pass = 1'b0;
        chk("t5_stray_busy", busy, 1'b0);
        chk("t5_stray_rep", repairable, 1'b0);
        do_start(8'h81);
        pcam_valid = 8'h00;
        step();
        step();
        // Ignored start and stray checker answer while scanning
        start    = 1'b1;
        chk_done = 1'b1;
        chk_pass = 1'b1;
        step();
        start    = 1'b0;
        chk_done = 1'b0;
        chk_pass = 1'b0;
        wait_strobe(300, n);
        chk("t5_strobe", dsss_valid, 1'b1);
        chk("t5_dsss", dsss, 8'h81);
        step();
        chk("t5_tried", tried_cnt, 8'd1);
        chk_done = 1'b1;
        chk_pass = 1'b1;
        step();
        chk_done = 1'b0;
        chk_pass = 1'b0;
        chk("t5_done", done, 1'b1);
        chk("t5_rep", repairable, 1'b1);
        step();
        chk("t5_idle", busy, 1'b0);
        chk("t5_dsss_hold", dsss, 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
